// File: rtl/add64_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add64_pkg : shared widths, defaults and response bundle for add64_rr_sched
// Rev 1.0
// ---------------------------------------------------------------------------
package add64_pkg;

    localparam int W        = 64;
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    localparam int IDW_MAX  = 3;
    localparam int CNTW_DEF = 16;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // id is sized for the largest supported requester count (8)
    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [W-1:0]       sum;
        logic               cout;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/adder_64.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_64 : 64-bit ripple-carry adder with carry-in and carry-out
// Rev 1.0
// ---------------------------------------------------------------------------
module adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int k = 0; k < 64; k++) begin
            sum[k] = a[k] ^ b[k] ^ c;
            c      = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        cout = c;
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin arbiter, search starts at last+1
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
    import add64_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        logic [IDW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // k = NREQ wraps back to last itself, so it is checked last
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_i) + k) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        if (en_i && any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/add64_rr_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add64_rr_sched : round-robin sharing of one 64-bit adder with a registered
//                  valid/ready result stage and saturating grant counters
// Rev 1.0
// ---------------------------------------------------------------------------
module add64_rr_sched
    import add64_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = add64_pkg::W,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_cout,
    output logic [NREQ*CNTW-1:0] grant_cnt
);

    out_state_e                 state_q, state_d;
    rsp_t                       rsp_q, rsp_d;
    logic [IDW-1:0]             last_q, last_d;
    logic [NREQ-1:0][CNTW-1:0]  cnt_q, cnt_d;

    logic                       can_issue;
    logic                       arb_en;
    logic [NREQ-1:0]            arb_gnt;
    logic [IDW-1:0]             arb_idx;
    logic                       arb_any;
    logic                       xfer;
    logic [IDW-1:0]             sel;
    logic [W-1:0]               op_a, op_b, add_sum;
    logic                       op_cin, add_cout;
    logic                       unused_id_bits;

    assign can_issue = (state_q == OUT_EMPTY) || rsp_ready;
    // Gating with rst keeps requests presented during reset from being accepted
    assign arb_en    = can_issue && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .en_i   (arb_en),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    assign req_ready = arb_gnt;
    assign xfer      = arb_any && arb_en;
    assign sel       = xfer ? arb_idx : '0;

    always_comb begin
        op_a   = req_a[W-1:0];
        op_b   = req_b[W-1:0];
        op_cin = req_cin[0];
        for (int i = 1; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                op_a   = req_a[i*W +: W];
                op_b   = req_b[i*W +: W];
                op_cin = req_cin[i];
            end
        end
    end

    adder_64 u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            state_d            = OUT_FULL;
            rsp_d.id           = '0;
            rsp_d.id[IDW-1:0]  = arb_idx;
            rsp_d.sum          = add_sum;
            rsp_d.cout         = add_cout;
            last_d             = arb_idx;
            if (cnt_q[arb_idx] != {CNTW{1'b1}}) begin
                cnt_d[arb_idx] = cnt_q[arb_idx] + 1'b1;
            end
        end else if (state_q == OUT_FULL && rsp_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
            rsp_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid      = (state_q == OUT_FULL);
    assign rsp_id         = rsp_q.id[IDW-1:0];
    assign rsp_sum        = rsp_q.sum;
    assign rsp_cout       = rsp_q.cout;
    assign grant_cnt      = cnt_q;
    assign unused_id_bits = ^rsp_q.id;

endmodule
`default_nettype wire

// File: doc/add64_rr_sched.md
# add64_rr_sched

Round-robin scheduler that shares one 64-bit ripple adder (`adder_64`) between several requesters. It arbitrates requests and registers each result into a single-entry output stage with valid/ready backpressure. Requests carry their own operands and carry-in; the one output channel returns each result tagged with the originating requester ID. It sits between the requester ports of the arithmetic cluster and the shared adder datapath, and keeps saturating per-requester grant counters for performance monitoring.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 64: operand width; fixed to match `adder_64`.
- `IDW`, default 2: requester ID width, equal to $clog_2(NREQ)$.
- `CNTW`, default 16: width of each grant counter.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NREQ: request valid, one bit per requester.
- `req_ready`, output, NREQ: request accepted this cycle; one-hot or zero.
- `req_a`, input, NREQ*W: operand A; requester i occupies bits [i*W +: W].
- `req_b`, input, NREQ*W: operand B, same packing as `req_a`.
- `req_cin`, input, NREQ: carry-in per requester.
- `rsp_valid`, output, 1: result register holds valid data.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_id`, output, IDW: requester index of the held result.
- `rsp_sum`, output, W: registered sum.
- `rsp_cout`, output, 1: registered carry-out.
- `grant_cnt`, output, NREQ*CNTW: saturating grant count per requester.

## Operation
- Issue condition: `can_issue = !rsp_valid || rsp_ready`.
- Arbitration:
  - Round-robin over `req_valid`, starting from `last+1` modulo NREQ.
  - The winner is the first asserted index found; `req_ready[winner]` = `can_issue`, and every other bit of `req_ready` is 0.
  - `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `last`.
- Datapath: the winner's `req_a`, `req_b` and `req_cin` are muxed into the internal `adder_64`. When no grant is made, the mux selects index 0; the output is ignored.
- Handshake:
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - A requester holds valid and operands stable until accepted. The scheduler must not depend on this for correctness of the current cycle.
- On transfer:
  - `rsp_sum`, `rsp_cout` and `rsp_id` load the adder result and the winner index.
  - `rsp_valid` is set to 1.
  - `last` is set to the winner index.
  - `grant_cnt[winner]` increments, saturating at all-ones.
- If `rsp_valid && rsp_ready` and no new transfer occurs in that cycle, `rsp_valid` is cleared to 0. Data registers hold their value.
- Simultaneous drain and issue: the result register reloads, `rsp_valid` stays 1, and there is no bubble.
- When `rsp_valid && !rsp_ready`: all `req_ready` bits are 0, and `last` and the counters hold.
- No valid requests: no grant is made and `last` holds.
- Output-register states: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY on a drain with no transfer.
  - FULL→FULL on a stall, or on a drain with a transfer.
- Arithmetic: the sum is (A+B+cin) mod 2^64, and `rsp_cout` is bit 64 of that addition.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, all `grant_cnt`=0, and `last`=NREQ-1 so that requester 0 has first priority. `req_ready` is 0 while `rst` is high.
- Reset mid-operation: the held result is dropped and requests presented during reset are not accepted. The first grant is possible in the cycle after `rst` deasserts.
- Latency: a request accepted at edge N shows `rsp_valid`=1 with its data after edge N, i.e. one cycle.
- Throughput: one result per cycle while `rsp_ready`=1.
- Fairness: with all requesters continuously valid and `rsp_ready`=1, grants rotate 0,1,2,3,0,... Each requester waits at most NREQ-1 issue slots.
- The combinational path runs through the arbiter, the operand mux and the 64-bit ripple adder into the result register. It must close in one `clk` period.

## Structure
- A shared package `add64_pkg` holds `W`=64, the default `NREQ`, `IDW`, `CNTW`, and a typedef for the response bundle (id, sum, cout).
- Sub-module `rr_arbiter`:
  - Parameterized by `NREQ`.
  - Inputs: request vector, `last` pointer, enable. Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register lives in the top.
- `adder_64` is instantiated once, unmodified.

## Test plan
- After reset: `rsp_valid`=0, `req_ready`=0, counters = 0. Then req0 with A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 → one cycle later `rsp_sum`=0, `rsp_cout`=1, `rsp_id`=0.
- All four requesters valid continuously, `rsp_ready`=1 for 8 cycles → grants 0,1,2,3,0,1,2,3, and each `grant_cnt` reads 2.
- Hold `rsp_ready`=0 while req1 and req2 are valid:
  - Exactly one result is held, then `req_ready`=0 for all requesters until drained.
  - On drain, the next grant goes in the same cycle with no bubble.
- Only req3 valid; A=0x8000_0000_0000_0000, B=0x8000_0000_0000_0000, cin=1 → `rsp_sum`=1, `rsp_cout`=1, `rsp_id`=3. Then req0 is granted next.
- Force `grant_cnt[0]` to 0xFFFE and issue 3 grants to req0 → the counter reads 0xFFFF and stays.
- Assert `rst` for one cycle while a result is held and two requests are pending → `rsp_valid` is 0 after the edge. The next grant goes to req0 if it is valid.
